// File: rtl/cpu_mem_responder.sv
// Wait-stated CPU bus responder backed by an internal byte memory.
// Optional macro CPU_MEM_RESP_ROM_EN write-protects addresses at or above ROM_BASE.
module cpu_mem_responder #(
  parameter int CPU_ABS_ADDR_MSB_POS = 15,
  parameter int CPU_DATA_MSB_POS     = 7,
  parameter int MEM_ADDR_WIDTH       = 10,
  parameter int WAIT_STATES          = 2,
  parameter logic [CPU_ABS_ADDR_MSB_POS:0] ROM_BASE = 16'h0300
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_rdwr,
  input  logic                        which_rdwr,
  input  logic [CPU_ABS_ADDR_MSB_POS:0] addr,
  input  logic [CPU_DATA_MSB_POS:0]   data_out,
  output logic [CPU_DATA_MSB_POS:0]   data_in,
  output logic                        ack,
  output logic                        busy,
  output logic                        err
);

  localparam int AW    = CPU_ABS_ADDR_MSB_POS + 1;
  localparam int DW    = CPU_DATA_MSB_POS + 1;
  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              wr_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW-1:0]     rdata_q;
  logic              ack_q;
  logic              busy_q;
  logic              err_q;
  logic [DW-1:0]     mem_q [DEPTH];

  logic                      go_d;
  logic                      act_wr;
  logic [AW-1:0]             act_addr;
  logic [DW-1:0]             act_data;
  logic [MEM_ADDR_WIDTH-1:0] act_idx;
  logic                      in_range;
  logic                      rom_hit;
  logic                      mem_we;
  logic [DW-1:0]             rdata_d;
  logic                      err_d;

  // With zero wait states the capture edge is also the edge entering RESP,
  // so the memory access must use the live bus rather than the captured copy.
  always_comb begin
    act_wr   = wr_q;
    act_addr = addr_q;
    act_data = wdata_q;
    go_d     = 1'b0;
    if (state_q == S_IDLE) begin
      act_wr   = which_rdwr;
      act_addr = addr;
      act_data = data_out;
      go_d     = req_rdwr && (WAIT_STATES == 0);
    end else if (state_q == S_WAIT) begin
      go_d = (cnt_q == 4'd1);
    end
  end

  assign act_idx  = act_addr[MEM_ADDR_WIDTH-1:0];
  assign in_range = (act_addr >> MEM_ADDR_WIDTH) == '0;

`ifdef CPU_MEM_RESP_ROM_EN
  assign rom_hit = (act_addr >= ROM_BASE);
`else
  logic unused_rom_base;
  assign rom_hit         = 1'b0;
  assign unused_rom_base = ^ROM_BASE;
`endif

  // rst gates the write so a reset held across the RESP-entry edge drops it.
  assign mem_we  = rst && go_d && act_wr && in_range && !rom_hit;
  assign rdata_d = in_range ? mem_q[act_idx] : '1;
  assign err_d   = go_d && (!in_range || (act_wr && rom_hit));

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[act_idx] <= act_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= go_d;
      err_q <= err_d;
      if (go_d && !act_wr) rdata_q <= rdata_d;
      case (state_q)
        S_IDLE: begin
          if (req_rdwr) begin
            wr_q    <= which_rdwr;
            addr_q  <= addr;
            wdata_q <= data_out;
            busy_q  <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(WAIT_STATES);
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (go_d) state_q <= S_RESP;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_in = rdata_q;
  assign ack     = ack_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: vector table, random traffic against an array model,
// zero-wait-state streaming and mid-cycle reset sequences.
module tb_cpu_mem_responder;

  localparam int WS = 2;
`ifdef CPU_MEM_RESP_ROM_EN
  localparam bit ROM_EN = 1'b1;
`else
  localparam bit ROM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0, which = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  dout = '0;
  logic [7:0]  data_in;
  logic        ack, busy, err;

  logic        req0 = 1'b0, which0 = 1'b0;
  logic [15:0] addr0 = '0;
  logic [7:0]  dout0 = '0;
  logic [7:0]  din0;
  logic        ack0, busy0, err0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mdl [1024];
  bit         vld [1024];
  logic [7:0] last_rd = 8'h00;
  bit         last_known = 1'b1;

  always #5 clk = ~clk;

  cpu_mem_responder #(.WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .req_rdwr(req), .which_rdwr(which), .addr(addr),
    .data_out(dout), .data_in(data_in), .ack(ack), .busy(busy), .err(err)
  );

  cpu_mem_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_rdwr(req0), .which_rdwr(which0), .addr(addr0),
    .data_out(dout0), .data_in(din0), .ack(ack0), .busy(busy0), .err(err0)
  );

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_d;
    logic        exp_err;
    bit          ck;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference behaviour: byte array, out-of-range above 1023, optional protected top region.
  task automatic model(input logic wr, input logic [15:0] a, input logic [7:0] d,
                       output logic [7:0] ed, output logic ee, output bit ck);
    bit oor, rom;
    oor = (a >= 16'd1024);
    rom = ROM_EN && !oor && (a >= 16'h0300);
    ee  = oor || (wr && rom);
    ed  = 8'h00;
    ck  = 1'b0;
    if (wr) begin
      if (!ee) begin
        mdl[a[9:0]] = d;
        vld[a[9:0]] = 1'b1;
      end
    end else if (oor) begin
      ed = 8'hFF;
      ck = 1'b1;
    end else begin
      ed = mdl[a[9:0]];
      ck = vld[a[9:0]];
    end
  endtask

  // Starts at a negedge, returns at the negedge after the response cycle.
  task automatic do_txn(input logic wr, input logic [15:0] a, input logic [7:0] d, input bit scr,
                        output logic [7:0] rd, output logic er);
    int  k;
    bit  seen;
    req = 1'b1; which = wr; addr = a; dout = d;
    @(posedge clk); #1;
    req = 1'b0;
    if (scr) begin
      which = ~wr; addr = a ^ 16'h0001; dout = ~d;
    end
    seen = 1'b0; k = 0; rd = '0; er = 1'b0;
    while (!seen && k < WS + 4) begin
      k++;
      @(negedge clk);
      if (ack === 1'b1) begin
        seen = 1'b1;
        check("ack_latency", k, WS + 1);
        check("busy_in_resp", busy, 1'b1);
        rd = data_in;
        er = err;
      end else begin
        check("busy_in_wait", busy, 1'b1);
      end
    end
    if (!seen) check("ack_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("ack_single", ack, 1'b0);
    check("err_single", err, 1'b0);
    check("busy_idle", busy, 1'b0);
  endtask

  task automatic exec(input string nm, input logic wr, input logic [15:0] a, input logic [7:0] d,
                      input bit scr, input logic [7:0] ed, input logic ee, input bit ck);
    logic [7:0] rd;
    logic       er;
    do_txn(wr, a, d, scr, rd, er);
    check({nm, "_err"}, er, ee);
    if (wr) begin
      if (last_known) check({nm, "_hold"}, rd, last_rd);
    end else begin
      if (ck) check({nm, "_data"}, rd, ed);
      last_known = ck;
      last_rd    = ed;
    end
  endtask

  initial begin
    vec_t       tbl [14];
    logic [7:0] ed;
    logic       ee;
    bit         ck;

    tbl[0]  = '{1'b1, 16'h0010, 8'hA5, 8'h00, 1'b0,   1'b0};
    tbl[1]  = '{1'b0, 16'h0010, 8'h00, 8'hA5, 1'b0,   1'b1};
    tbl[2]  = '{1'b1, 16'h0000, 8'h33, 8'h00, 1'b0,   1'b0};
    tbl[3]  = '{1'b1, 16'h8000, 8'h77, 8'h00, 1'b1,   1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 8'h00, 8'h33, 1'b0,   1'b1};
    tbl[5]  = '{1'b0, 16'h8000, 8'h00, 8'hFF, 1'b1,   1'b1};
    tbl[6]  = '{1'b0, 16'h0400, 8'h00, 8'hFF, 1'b1,   1'b1};
    tbl[7]  = '{1'b1, 16'h03FF, 8'h5C, 8'h00, ROM_EN, 1'b0};
    tbl[8]  = '{1'b0, 16'h03FF, 8'h00, 8'h5C, 1'b0,   !ROM_EN};
    tbl[9]  = '{1'b1, 16'h02FF, 8'h99, 8'h00, 1'b0,   1'b0};
    tbl[10] = '{1'b0, 16'h02FF, 8'h00, 8'h99, 1'b0,   1'b1};
    tbl[11] = '{1'b1, 16'h0300, 8'h22, 8'h00, ROM_EN, 1'b0};
    tbl[12] = '{1'b0, 16'h0300, 8'h00, 8'h22, 1'b0,   !ROM_EN};
    tbl[13] = '{1'b0, 16'h0010, 8'h00, 8'hA5, 1'b0,   1'b1};

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_ack", ack, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_data", data_in, 8'h00);
    check("rst0_busy", busy0, 1'b0);
    check("rst0_data", din0, 8'h00);
    rst = 1'b1;

    // Zero wait states, request held high: 4 writes then 4 reads, one ack every 2nd clock.
    req0 = 1'b1; which0 = 1'b1; addr0 = 16'h0000; dout0 = 8'h40;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n % 2 == 1) begin
        int j;
        j = (n - 1) / 2;
        check($sformatf("ws0_ack_%0d", n), ack0, 1'b1);
        check($sformatf("ws0_busy_%0d", n), busy0, 1'b1);
        check($sformatf("ws0_err_%0d", n), err0, 1'b0);
        check($sformatf("ws0_data_%0d", n), din0, (j < 4) ? 8'h00 : 8'h40 + 8'(j - 4));
        j = (n + 1) / 2;
        if (j < 4) begin
          which0 = 1'b1; addr0 = 16'(j); dout0 = 8'h40 + 8'(j);
        end else if (j < 8) begin
          which0 = 1'b0; addr0 = 16'(j - 4); dout0 = 8'hEE;
        end else begin
          req0 = 1'b0;
        end
      end else begin
        check($sformatf("ws0_ack_%0d", n), ack0, 1'b0);
        check($sformatf("ws0_busy_%0d", n), busy0, 1'b0);
      end
    end

    for (int i = 0; i < 14; i++) begin
      model(tbl[i].wr, tbl[i].a, tbl[i].d, ed, ee, ck);
      exec($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].a, tbl[i].d, 1'b0,
           tbl[i].exp_d, tbl[i].exp_err, tbl[i].ck);
    end

    // Bus changes after capture must not redirect the write.
    model(1'b1, 16'h0045, 8'h12, ed, ee, ck);
    exec("pre45", 1'b1, 16'h0045, 8'h12, 1'b0, ed, ee, ck);
    model(1'b1, 16'h0044, 8'h6E, ed, ee, ck);
    exec("scr44", 1'b1, 16'h0044, 8'h6E, 1'b1, ed, ee, ck);
    exec("rd44", 1'b0, 16'h0044, 8'h00, 1'b0, 8'h6E, 1'b0, 1'b1);
    exec("rd45", 1'b0, 16'h0045, 8'h00, 1'b0, 8'h12, 1'b0, 1'b1);

    for (int t = 0; t < 200; t++) begin
      logic [15:0] a;
      logic        wr;
      logic [7:0]  d;
      int unsigned r;
      r = $urandom_range(0, 7);
      if (r == 0)     a = 16'($urandom_range(16'h0400, 16'hFFFF));
      else if (r < 3) a = 16'h02F8 + 16'($urandom_range(0, 15));
      else            a = 16'($urandom_range(0, 63));
      wr = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      model(wr, a, d, ed, ee, ck);
      exec($sformatf("rnd%0d", t), wr, a, d, 1'($urandom_range(0, 1)), ed, ee, ck);
    end

    // Reset while in WAIT abandons the write of 3C.
    model(1'b1, 16'h0020, 8'h5A, ed, ee, ck);
    exec("pre20", 1'b1, 16'h0020, 8'h5A, 1'b0, ed, ee, ck);
    exec("rd20a", 1'b0, 16'h0020, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b1);
    req = 1'b1; which = 1'b1; addr = 16'h0020; dout = 8'h3C;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ack", ack, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_data", data_in, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check($sformatf("post_rst_ack_%0d", n), ack, 1'b0);
    end
    last_rd = 8'h00; last_known = 1'b1;

    // Reset held across the edge that would enter RESP.
    req = 1'b1; which = 1'b1; addr = 16'h0020; dout = 8'hC3;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("edge_rst_ack", ack, 1'b0);
    check("edge_rst_busy", busy, 1'b0);
    @(negedge clk);
    check("edge_rst_ack2", ack, 1'b0);
    exec("rd20b", 1'b0, 16'h0020, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
